hpdcache_mshr_refill: RTL and testbench

Refill responder paired with the MSHR. It accepts multi-beat memory read responses whose transaction ID encodes an MSHR {way, set} slot, and arbitrates for the MSHR port to acknowledge (free) that slot. It streams the refill line into the cache data/directory write port and, if the original miss needs one, returns the requested word to the core. It sits between the memory response channel and the cache controller pipeline, on the opposite end from MSHR allocation.

---
 rtl/hpdcache_pkg.sv | 35 +++
 rtl/hpdcache_refill_word_sel.sv | 23 ++
 rtl/hpdcache_mshr_refill.sv | 209 ++++++++++++++++++++
 tb/tb_hpdcache_mshr_refill.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache MSHR refill path.
// Refill error tracking is enabled by defining HPDCACHE_REFILL_ERROR_EN.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_SET_W  = 7;
  localparam int unsigned HPDCACHE_TAG_W  = 20;
  localparam int unsigned HPDCACHE_TID_W  = 8;
  localparam int unsigned HPDCACHE_SID_W  = 3;
  localparam int unsigned HPDCACHE_WIDX_W = 3;

  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    REFILL_IDLE = 3'd0,
    REFILL_ARB  = 3'd1,
    REFILL_META = 3'd2,
    REFILL_FILL = 3'd3,
    REFILL_RSP  = 3'd4
  } hpdcache_refill_fsm_e;

  typedef struct packed {
    logic [HPDCACHE_TAG_W-1:0]  tag;
    logic [HPDCACHE_SET_W-1:0]  set;
    logic [HPDCACHE_TID_W-1:0]  tid;
    logic [HPDCACHE_SID_W-1:0]  sid;
    logic [HPDCACHE_WIDX_W-1:0] word;
    logic                       need_rsp;
    logic                       is_prefetch;
  } mshr_ack_meta_t;

endpackage

// File: rtl/hpdcache_refill_word_sel.sv
// Picks one core word out of a refill beat.
module hpdcache_refill_word_sel
  import hpdcache_pkg::*;
#(
  parameter  int unsigned WordWidth    = 64,
  parameter  int unsigned WordsPerBeat = 2,
  localparam int unsigned OffWidth     = clog2_min1(WordsPerBeat)
) (
  input  logic [WordsPerBeat*WordWidth-1:0] beat_i,
  input  logic [OffWidth-1:0]               off_i,
  output logic [WordWidth-1:0]              word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned w = 0; w < WordsPerBeat; w++) begin
      if (off_i == OffWidth'(w)) begin
        word_o = beat_i[w*WordWidth +: WordWidth];
      end
    end
  end

endmodule

// File: rtl/hpdcache_mshr_refill.sv
// MSHR refill responder: frees the MSHR slot, streams the line, answers the core.
// Define HPDCACHE_REFILL_ERROR_EN to track bus errors across the fill.
module hpdcache_mshr_refill
  import hpdcache_pkg::*;
#(
  parameter  int unsigned MshrSets      = 4,
  parameter  int unsigned MshrWays      = 4,
  parameter  int unsigned SetWidth      = HPDCACHE_SET_W,
  parameter  int unsigned TagWidth      = HPDCACHE_TAG_W,
  parameter  int unsigned WordWidth     = 64,
  parameter  int unsigned WordsPerBeat  = 2,
  parameter  int unsigned Beats         = 4,
  parameter  int unsigned TidWidth      = HPDCACHE_TID_W,
  parameter  int unsigned SidWidth      = HPDCACHE_SID_W,
  localparam int unsigned MshrSetWidth  = clog2_min1(MshrSets),
  localparam int unsigned MshrWayWidth  = clog2_min1(MshrWays),
  localparam int unsigned WordIdxWidth  = $clog2(Beats*WordsPerBeat),
  localparam int unsigned BeatWidth     = clog2_min1(Beats),
  localparam int unsigned BeatDataWidth = WordsPerBeat*WordWidth,
  localparam int unsigned OffWidth      = clog2_min1(WordsPerBeat)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,

  input  logic                           mem_rsp_valid_i,
  output logic                           mem_rsp_ready_o,
  input  logic [MshrWayWidth+MshrSetWidth-1:0] mem_rsp_id_i,
  input  logic [BeatDataWidth-1:0]       mem_rsp_data_i,
  input  logic                           mem_rsp_last_i,
  input  logic                           mem_rsp_error_i,

  output logic                           refill_req_o,
  input  logic                           refill_gnt_i,

  output logic                           mshr_ack_o,
  output logic                           mshr_ack_cs_o,
  output logic [MshrSetWidth-1:0]        mshr_ack_set_o,
  output logic [MshrWayWidth-1:0]        mshr_ack_way_o,
  input  logic [TidWidth-1:0]            mshr_ack_req_id_i,
  input  logic [SidWidth-1:0]            mshr_ack_src_id_i,
  input  logic [SetWidth-1:0]            mshr_ack_cache_set_i,
  input  logic [TagWidth-1:0]            mshr_ack_cache_tag_i,
  input  logic [WordIdxWidth-1:0]        mshr_ack_word_i,
  input  logic                           mshr_ack_need_rsp_i,
  input  logic                           mshr_ack_is_prefetch_i,

  output logic                           refill_write_o,
  output logic [SetWidth-1:0]            refill_set_o,
  output logic [TagWidth-1:0]            refill_tag_o,
  output logic [BeatWidth-1:0]           refill_beat_o,
  output logic [BeatDataWidth-1:0]       refill_data_o,
  output logic                           refill_dir_o,

  output logic                           core_rsp_valid_o,
  input  logic                           core_rsp_ready_i,
  output logic [TidWidth-1:0]            core_rsp_tid_o,
  output logic [SidWidth-1:0]            core_rsp_sid_o,
  output logic [WordWidth-1:0]           core_rsp_data_o,
  output logic                           core_rsp_error_o
);

  hpdcache_refill_fsm_e    state_q;
  logic [MshrSetWidth-1:0] set_q;
  logic [MshrWayWidth-1:0] way_q;
  mshr_ack_meta_t          meta_q;
  mshr_ack_meta_t          meta_in;
  logic [BeatWidth-1:0]    beat_q;
  logic [WordWidth-1:0]    word_q;

  logic                    beat_acc;
  logic                    beat_hit;
  logic                    beat_end;
  logic                    ack_drv;
  logic                    need_core_rsp;
  logic                    fill_err;
  logic                    rsp_err;
  logic [BeatWidth-1:0]    word_beat;
  logic [OffWidth-1:0]     word_off;
  logic [WordWidth-1:0]    sel_word;

  always_comb begin
    meta_in             = '0;
    meta_in.tag         = mshr_ack_cache_tag_i;
    meta_in.set         = mshr_ack_cache_set_i;
    meta_in.tid         = mshr_ack_req_id_i;
    meta_in.sid         = mshr_ack_src_id_i;
    meta_in.word        = mshr_ack_word_i;
    meta_in.need_rsp    = mshr_ack_need_rsp_i;
    meta_in.is_prefetch = mshr_ack_is_prefetch_i;
  end

  // Requested word lives in beat word/WordsPerBeat, at offset word%WordsPerBeat
  assign word_beat = BeatWidth'(32'(meta_q.word) / WordsPerBeat);
  assign word_off  = OffWidth'(32'(meta_q.word) % WordsPerBeat);

  assign beat_acc      = (state_q == REFILL_FILL) && mem_rsp_valid_i;
  assign beat_hit      = beat_acc && (beat_q == word_beat);
  assign beat_end      = beat_q == BeatWidth'(Beats-1);
  assign need_core_rsp = meta_q.need_rsp && !meta_q.is_prefetch;

  hpdcache_refill_word_sel #(
    .WordWidth    (WordWidth),
    .WordsPerBeat (WordsPerBeat)
  ) i_word_sel (
    .beat_i (mem_rsp_data_i),
    .off_i  (word_off),
    .word_o (sel_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REFILL_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      meta_q  <= '0;
      beat_q  <= '0;
      word_q  <= '0;
    end else begin
      unique case (state_q)
        REFILL_IDLE: begin
          if (mem_rsp_valid_i) begin
            set_q   <= mem_rsp_id_i[MshrSetWidth-1:0];
            way_q   <= mem_rsp_id_i[MshrSetWidth +: MshrWayWidth];
            state_q <= REFILL_ARB;
          end
        end
        REFILL_ARB: begin
          if (refill_gnt_i) state_q <= REFILL_META;
        end
        REFILL_META: begin
          meta_q  <= meta_in;
          state_q <= REFILL_FILL;
        end
        REFILL_FILL: begin
          if (mem_rsp_valid_i) begin
            if (beat_hit) word_q <= sel_word;
            if (mem_rsp_last_i) begin
              beat_q  <= '0;
              state_q <= need_core_rsp ? REFILL_RSP : REFILL_IDLE;
            end else begin
              beat_q  <= beat_q + BeatWidth'(1);
            end
          end
        end
        REFILL_RSP: begin
          if (core_rsp_ready_i) state_q <= REFILL_IDLE;
        end
        default: state_q <= REFILL_IDLE;
      endcase
    end
  end

`ifdef HPDCACHE_REFILL_ERROR_EN
  logic err_q;

  // Sticky over one fill; cleared when a new response wins IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == REFILL_IDLE) && mem_rsp_valid_i) begin
      err_q <= 1'b0;
    end else if (beat_acc) begin
      err_q <= err_q | mem_rsp_error_i;
    end
  end

  assign fill_err = err_q | mem_rsp_error_i;
  assign rsp_err  = err_q;
`else
  logic unused_err;

  assign unused_err = mem_rsp_error_i;
  assign fill_err   = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign ack_drv = (state_q == REFILL_ARB) || (state_q == REFILL_META);

  assign mem_rsp_ready_o = state_q == REFILL_FILL;
  assign refill_req_o    = state_q == REFILL_ARB;
  assign mshr_ack_o      = refill_req_o && refill_gnt_i;
  assign mshr_ack_cs_o   = mshr_ack_o;
  assign mshr_ack_set_o  = ack_drv ? set_q : '0;
  assign mshr_ack_way_o  = ack_drv ? way_q : '0;

  assign refill_write_o = beat_acc;
  assign refill_set_o   = beat_acc ? meta_q.set : '0;
  assign refill_tag_o   = beat_acc ? meta_q.tag : '0;
  assign refill_beat_o  = beat_acc ? beat_q : '0;
  assign refill_data_o  = beat_acc ? mem_rsp_data_i : '0;
  assign refill_dir_o   = beat_acc && mem_rsp_last_i && !fill_err;

  assign core_rsp_valid_o = state_q == REFILL_RSP;
  assign core_rsp_tid_o   = core_rsp_valid_o ? meta_q.tid : '0;
  assign core_rsp_sid_o   = core_rsp_valid_o ? meta_q.sid : '0;
  assign core_rsp_data_o  = core_rsp_valid_o ? word_q : '0;
  assign core_rsp_error_o = core_rsp_valid_o && rsp_err;

  a_last_on_final_beat: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (beat_acc && beat_end) |-> mem_rsp_last_i
  );

  a_no_early_last: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (beat_acc && mem_rsp_last_i) |-> beat_end
  );

endmodule

// File: tb/tb_hpdcache_mshr_refill.sv
// Self-checking bench for hpdcache_mshr_refill (directed table + random).
module tb_hpdcache_mshr_refill;
  import hpdcache_pkg::*;

  localparam int SETS = 4;
  localparam int WAYS = 4;
  localparam int SW   = 7;
  localparam int TW   = 20;
  localparam int WW   = 64;
  localparam int WPB  = 2;
  localparam int NB   = 4;
  localparam int TIDW = 8;
  localparam int SIDW = 3;
  localparam int MSW  = 2;
  localparam int MWW  = 2;
  localparam int WIW  = 3;
  localparam int BW   = 2;
  localparam int BDW  = WPB*WW;
  localparam int MAXCYC = 200;
  localparam int NRND   = 30;

`ifdef HPDCACHE_REFILL_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_ni;
  logic             mem_rsp_valid_i;
  logic             mem_rsp_ready_o;
  logic [MWW+MSW-1:0] mem_rsp_id_i;
  logic [BDW-1:0]   mem_rsp_data_i;
  logic             mem_rsp_last_i;
  logic             mem_rsp_error_i;
  logic             refill_req_o;
  logic             refill_gnt_i;
  logic             mshr_ack_o;
  logic             mshr_ack_cs_o;
  logic [MSW-1:0]   mshr_ack_set_o;
  logic [MWW-1:0]   mshr_ack_way_o;
  logic [TIDW-1:0]  mshr_ack_req_id_i;
  logic [SIDW-1:0]  mshr_ack_src_id_i;
  logic [SW-1:0]    mshr_ack_cache_set_i;
  logic [TW-1:0]    mshr_ack_cache_tag_i;
  logic [WIW-1:0]   mshr_ack_word_i;
  logic             mshr_ack_need_rsp_i;
  logic             mshr_ack_is_prefetch_i;
  logic             refill_write_o;
  logic [SW-1:0]    refill_set_o;
  logic [TW-1:0]    refill_tag_o;
  logic [BW-1:0]    refill_beat_o;
  logic [BDW-1:0]   refill_data_o;
  logic             refill_dir_o;
  logic             core_rsp_valid_o;
  logic             core_rsp_ready_i;
  logic [TIDW-1:0]  core_rsp_tid_o;
  logic [SIDW-1:0]  core_rsp_sid_o;
  logic [WW-1:0]    core_rsp_data_o;
  logic             core_rsp_error_o;

  hpdcache_mshr_refill dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .mem_rsp_valid_i        (mem_rsp_valid_i),
    .mem_rsp_ready_o        (mem_rsp_ready_o),
    .mem_rsp_id_i           (mem_rsp_id_i),
    .mem_rsp_data_i         (mem_rsp_data_i),
    .mem_rsp_last_i         (mem_rsp_last_i),
    .mem_rsp_error_i        (mem_rsp_error_i),
    .refill_req_o           (refill_req_o),
    .refill_gnt_i           (refill_gnt_i),
    .mshr_ack_o             (mshr_ack_o),
    .mshr_ack_cs_o          (mshr_ack_cs_o),
    .mshr_ack_set_o         (mshr_ack_set_o),
    .mshr_ack_way_o         (mshr_ack_way_o),
    .mshr_ack_req_id_i      (mshr_ack_req_id_i),
    .mshr_ack_src_id_i      (mshr_ack_src_id_i),
    .mshr_ack_cache_set_i   (mshr_ack_cache_set_i),
    .mshr_ack_cache_tag_i   (mshr_ack_cache_tag_i),
    .mshr_ack_word_i        (mshr_ack_word_i),
    .mshr_ack_need_rsp_i    (mshr_ack_need_rsp_i),
    .mshr_ack_is_prefetch_i (mshr_ack_is_prefetch_i),
    .refill_write_o         (refill_write_o),
    .refill_set_o           (refill_set_o),
    .refill_tag_o           (refill_tag_o),
    .refill_beat_o          (refill_beat_o),
    .refill_data_o          (refill_data_o),
    .refill_dir_o           (refill_dir_o),
    .core_rsp_valid_o       (core_rsp_valid_o),
    .core_rsp_ready_i       (core_rsp_ready_i),
    .core_rsp_tid_o         (core_rsp_tid_o),
    .core_rsp_sid_o         (core_rsp_sid_o),
    .core_rsp_data_o        (core_rsp_data_o),
    .core_rsp_error_o       (core_rsp_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{mem_rsp_ready_o, refill_req_o, mshr_ack_o,
    mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o, refill_write_o,
    refill_set_o, refill_tag_o, refill_beat_o, refill_data_o,
    refill_dir_o, core_rsp_valid_o, core_rsp_tid_o, core_rsp_sid_o,
    core_rsp_data_o, core_rsp_error_o};

  typedef struct {
    int set;
    int way;
    int tid;
    int sid;
    int cset;
    int ctag;
    int word;
    bit need;
    bit pf;
    int gnt_wait;
    int rdy_wait;
    int err_beat;
    int rst_beat;
    bit exp_rsp;
    bit exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WW-1:0] line_m [NB*WPB];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BDW-1:0] beat_data(input int b);
    logic [BDW-1:0] d;
    d = '0;
    for (int w = 0; w < WPB; w++) d[w*WW +: WW] = line_m[b*WPB+w];
    return d;
  endfunction

  function automatic vec_t mk(input int set, input int way,
    input int word, input bit need, input bit pf, input int gw,
    input int rw, input int eb, input int rb);
    vec_t v;
    v.set = set; v.way = way;
    v.tid = int'($urandom_range(0, 255));
    v.sid = int'($urandom_range(0, 7));
    v.cset = int'($urandom_range(0, 127));
    v.ctag = int'($urandom_range(0, 20'hfffff));
    v.word = word; v.need = need; v.pf = pf;
    v.gnt_wait = gw; v.rdy_wait = rw;
    v.err_beat = eb; v.rst_beat = rb;
    v.exp_rsp = need && !pf;
    v.exp_err = ERR_EN && (eb >= 0);
    return v;
  endfunction

  task automatic idle_inputs();
    mem_rsp_valid_i = 0; mem_rsp_id_i = '0; mem_rsp_data_i = '0;
    mem_rsp_last_i = 0; mem_rsp_error_i = 0; refill_gnt_i = 0;
    core_rsp_ready_i = 0;
    mshr_ack_req_id_i = '0; mshr_ack_src_id_i = '0;
    mshr_ack_cache_set_i = '0; mshr_ack_cache_tag_i = '0;
    mshr_ack_word_i = '0; mshr_ack_need_rsp_i = 0;
    mshr_ack_is_prefetch_i = 0;
  endtask

  // Environment: memory, MSHR (1-cycle read) and core, checked against v
  task automatic run(input vec_t v);
    logic [MWW+MSW-1:0] id;
    int cyc, beat, req_cnt, ack_cyc, first_wr, last_wr;
    int rsp_cyc, rsp_cnt, n_ack;
    bit done, prev_ack, aborted;
    for (int i = 0; i < NB*WPB; i++) line_m[i] = {$urandom, $urandom};
    id = {MWW'(v.way), MSW'(v.set)};
    cyc = 0; beat = 0; req_cnt = 0; n_ack = 0; rsp_cnt = 0;
    ack_cyc = -1; first_wr = -1; last_wr = -1; rsp_cyc = -1;
    done = 0; prev_ack = 0; aborted = 0;
    while (!done && cyc < MAXCYC) begin
      @(negedge clk);
      refill_gnt_i = req_cnt >= v.gnt_wait;
      core_rsp_ready_i = rsp_cnt >= v.rdy_wait;
      if (prev_ack) begin
        mshr_ack_req_id_i = TIDW'(v.tid);
        mshr_ack_src_id_i = SIDW'(v.sid);
        mshr_ack_cache_set_i = SW'(v.cset);
        mshr_ack_cache_tag_i = TW'(v.ctag);
        mshr_ack_word_i = WIW'(v.word);
        mshr_ack_need_rsp_i = v.need;
        mshr_ack_is_prefetch_i = v.pf;
      end else begin
        mshr_ack_req_id_i = TIDW'($urandom);
        mshr_ack_src_id_i = SIDW'($urandom);
        mshr_ack_cache_set_i = SW'($urandom);
        mshr_ack_cache_tag_i = TW'($urandom);
        mshr_ack_word_i = WIW'($urandom);
        mshr_ack_need_rsp_i = 1'($urandom);
        mshr_ack_is_prefetch_i = 1'($urandom);
      end
      if (beat < NB) begin
        mem_rsp_valid_i = 1;
        mem_rsp_id_i = id;
        mem_rsp_data_i = beat_data(beat);
        mem_rsp_last_i = beat == NB-1;
        mem_rsp_error_i = beat == v.err_beat;
      end else begin
        // next response waiting while the core holds us in RSP
        mem_rsp_valid_i = 1;
        mem_rsp_id_i = ~id;
        mem_rsp_last_i = 0;
        mem_rsp_error_i = 0;
      end
      #1;
      if (cyc == 0) begin
        chk("idle_ready", mem_rsp_ready_o, 0);
        chk("idle_req", refill_req_o, 0);
      end
      if (refill_req_o) begin
        req_cnt++;
        if (req_cnt == 1) chk("arb_latency", cyc, 1);
        chk("arb_no_pop", mem_rsp_ready_o, 0);
      end
      if (mshr_ack_o) begin
        n_ack++;
        ack_cyc = cyc;
        chk("ack_cs", mshr_ack_cs_o, 1);
        chk("ack_set", mshr_ack_set_o, v.set);
        chk("ack_way", mshr_ack_way_o, v.way);
        chk("gnt_wait", req_cnt, v.gnt_wait + 1);
      end
      prev_ack = mshr_ack_o;
      if (refill_write_o) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        chk("wr_beat", refill_beat_o, beat);
        chk("wr_data", refill_data_o, beat_data(beat));
        chk("wr_set", refill_set_o, v.cset);
        chk("wr_tag", refill_tag_o, v.ctag);
        chk("wr_dir", refill_dir_o, (beat == NB-1) && !v.exp_err);
        beat++;
        if (v.rst_beat >= 0 && beat - 1 == v.rst_beat) begin
          rst_ni = 0;
          #1;
          chk("rst_outs_zero", any_out, 0);
          aborted = 1;
          done = 1;
        end
      end
      if (core_rsp_valid_o) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc;
          chk("rsp_expected", 1, v.exp_rsp);
          chk("rsp_latency", rsp_cyc, last_wr + 1);
        end
        chk("rsp_data", core_rsp_data_o, line_m[v.word]);
        chk("rsp_tid", core_rsp_tid_o, v.tid);
        chk("rsp_sid", core_rsp_sid_o, v.sid);
        chk("rsp_err", core_rsp_error_o, v.exp_err);
        chk("rsp_no_accept", {mem_rsp_ready_o, refill_req_o}, 0);
        rsp_cnt++;
        if (core_rsp_ready_i) done = 1;
      end
      if (!v.exp_rsp && beat == NB) done = 1;
      cyc++;
    end
    chk("timeout", done, 1);
    if (!aborted) begin
      chk("n_ack", n_ack, 1);
      chk("n_writes", beat, NB);
      chk("fill_start", first_wr, ack_cyc + 2);
      if (v.exp_rsp) chk("rsp_hold", rsp_cnt, v.rdy_wait + 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("back_idle", {core_rsp_valid_o, mem_rsp_ready_o, refill_req_o}, 0);
    end
  endtask

  vec_t vecs [8];

  initial begin
    idle_inputs();
    rst_ni = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", any_out, 0);
    @(negedge clk);
    rst_ni = 1;

    //         set way wrd nd pf gw rw  eb  rb
    vecs[0] = mk(2, 1, 5, 1, 0, 0, 0, -1, -1);
    vecs[1] = mk(3, 0, 2, 1, 1, 0, 0, -1, -1);
    vecs[2] = mk(1, 3, 1, 1, 0, 5, 0, -1, -1);
    vecs[3] = mk(0, 2, 0, 1, 0, 0, 3, -1, -1);
    vecs[4] = mk(2, 2, 6, 1, 0, 1, 1,  1, -1);
    vecs[5] = mk(1, 1, 3, 1, 0, 0, 0, -1, -1);
    vecs[6] = mk(3, 3, 7, 0, 0, 2, 0, -1, -1);
    vecs[7] = mk(0, 0, 4, 0, 0, 0, 0,  3, -1);
    foreach (vecs[i]) run(vecs[i]);

    for (int i = 0; i < NRND; i++) begin
      run(mk(int'($urandom_range(0, SETS-1)),
             int'($urandom_range(0, WAYS-1)),
             int'($urandom_range(0, NB*WPB-1)),
             1'($urandom), $urandom_range(0, 3) == 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ?
               int'($urandom_range(0, NB-1)) : -1,
             -1));
    end

    // Reset during beat 2, then a fresh refill
    run(mk(1, 2, 3, 1, 0, 0, 0, -1, 2));
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rst_hold_zero", any_out, 0);
    @(negedge clk);
    rst_ni = 1;
    run(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
